bcd_game_timer: RTL and testbench

- Elapsed-time source for the Road Rage HUD.
- Generates a 1 s tick from CLOCK_50 and counts game seconds in two BCD digits (00–99).
- Game control: start, pause, clear, game-over on collision, saturation at 99.
- Digit outputs drive the two seg7decoder instances on HEX1/HEX0 directly.
- Replaces the free-running counter with a controlled, strictly BCD-legal one.

---
 rtl/road_rage_pkg.sv | 26 ++
 rtl/bcd_game_timer_if.sv | 25 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/bcd_game_timer.sv | 118 +++++++++++
 tb/tb_bcd_game_timer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/road_rage_pkg.sv
// Shared types and constants for the Road Rage HUD timing blocks.
package road_rage_pkg;

    localparam int CLK_HZ = 50000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Two-digit BCD increment; the caller guarantees the result stays in range.
    function automatic logic [7:0] bcd_inc(input bcd_digit_t tens, input bcd_digit_t ones);
        logic [7:0] res;
        if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_game_timer_if.sv
// Control and display bundle between game logic and the BCD game timer.
interface bcd_game_timer_if;
    import road_rage_pkg::*;

    logic       start;
    logic       pause;
    logic       clear;
    logic       collision;
    bcd_digit_t ones;
    bcd_digit_t tens;
    logic       running;
    logic       done;
    logic       sec_pulse;

    modport master (
        output start, pause, clear, collision,
        input  ones, tens, running, done, sec_pulse
    );

    modport slave (
        input  start, pause, clear, collision,
        output ones, tens, running, done, sec_pulse
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every N enabled cycles.
module tick_prescaler #(
    parameter int N = road_rage_pkg::CLK_HZ
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int         W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_r;

    assign tick = en && (cnt_r == LAST);

    // Prescaler count: advances only when enabled, otherwise holds its phase.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (sync_clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= tick ? '0 : cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_game_timer.sv
// Game elapsed-time counter: two saturating BCD digits with start/pause/clear/game-over control.
module bcd_game_timer
    import road_rage_pkg::*;
#(
    parameter int TICKS_PER_SEC = CLK_HZ,
    parameter int MAX_TENS      = 9
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    bcd_game_timer_if.slave  bus
);
    localparam bcd_digit_t TOP_TENS = 4'(MAX_TENS);

    timer_state_t state_r, state_s;
    bcd_digit_t   ones_r, tens_r, ones_s, tens_s;
    logic         pulse_r, pulse_s;
    logic         running_r, done_r;
    logic         run_s, tick_s, at_max_s;

    assign run_s = (state_r == RUN);

    tick_prescaler #(.N(TICKS_PER_SEC)) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (run_s),
        .sync_clr (bus.clear),
        .tick     (tick_s)
    );

    // Next-state, digit and pulse logic; clear beats collision beats pause beats start.
    always_comb begin
        state_s  = state_r;
        ones_s   = ones_r;
        tens_s   = tens_r;
        pulse_s  = 1'b0;
        at_max_s = (tens_r == TOP_TENS) && (ones_r == 4'd9);
        if (bus.clear) begin
            state_s = IDLE;
            ones_s  = 4'd0;
            tens_s  = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.collision) begin
                        state_s = OVER;
                    end else if (bus.start) begin
                        state_s = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (bus.collision) begin
                        state_s = OVER;
                    end else if (tick_s && at_max_s) begin
                        state_s = OVER;
                    end else begin
                        // A tick coinciding with pause still lands before freezing.
                        if (tick_s) begin
                            {tens_s, ones_s} = bcd_inc(tens_r, ones_r);
                            pulse_s          = 1'b1;
                        end else begin
                            pulse_s = 1'b0;
                        end
                        if (bus.pause) begin
                            state_s = PAUSED;
                        end else begin
                            state_s = RUN;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.collision) begin
                        state_s = OVER;
                    end else if (bus.start && !bus.pause) begin
                        state_s = RUN;
                    end else begin
                        state_s = PAUSED;
                    end
                end
                OVER: begin
                    state_s = OVER;
                end
                default: begin
                    state_s = IDLE;
                    ones_s  = 4'd0;
                    tens_s  = 4'd0;
                end
            endcase
        end
    end

    // State, digit and status registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            ones_r    <= 4'd0;
            tens_r    <= 4'd0;
            pulse_r   <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            ones_r    <= ones_s;
            tens_r    <= tens_s;
            pulse_r   <= pulse_s;
            running_r <= (state_s == RUN);
            done_r    <= (state_s == OVER);
        end
    end

    assign bus.ones      = ones_r;
    assign bus.tens      = tens_r;
    assign bus.sec_pulse = pulse_r;
    assign bus.running   = running_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_bcd_game_timer.sv
// Randomised scoreboard bench for bcd_game_timer against an elapsed-seconds reference model.
module tb_bcd_game_timer;

    localparam int T     = 4;
    localparam int MT    = 9;
    localparam int MAXS  = MT * 10 + 9;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bcd_game_timer_if intf ();

    bcd_game_timer #(.TICKS_PER_SEC(T), .MAX_TENS(MT)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (intf)
    );

    typedef struct {
        int ones;
        int tens;
        bit running;
        bit done;
        bit pulse;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: elapsed seconds as a plain integer, sub-second phase, game mode.
    int m_secs, m_phase, m_mode;
    bit m_pulse;

    function automatic void model_reset();
        m_secs  = 0;
        m_phase = 0;
        m_mode  = M_IDLE;
        m_pulse = 1'b0;
    endfunction

    function automatic void model_step(input bit st, input bit ps, input bit cl, input bit co);
        bit tick;
        tick    = (m_mode == M_RUN) && (m_phase == T - 1);
        m_pulse = 1'b0;
        if (cl) begin
            model_reset();
        end else begin
            if (m_mode == M_RUN) m_phase = (m_phase + 1) % T;
            case (m_mode)
                M_IDLE:  if (co) m_mode = M_OVER; else if (st) m_mode = M_RUN;
                M_RUN: begin
                    if (co) m_mode = M_OVER;
                    else begin
                        if (tick) begin
                            if (m_secs == MAXS) m_mode = M_OVER;
                            else begin
                                m_secs  = m_secs + 1;
                                m_pulse = 1'b1;
                            end
                        end
                        if (ps && m_mode == M_RUN) m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (co) m_mode = M_OVER; else if (st && !ps) m_mode = M_RUN;
                default: ;
            endcase
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.ones    = m_secs % 10;
        e.tens    = m_secs / 10;
        e.running = (m_mode == M_RUN);
        e.done    = (m_mode == M_OVER);
        e.pulse   = m_pulse;
        q.push_back(e);
    endfunction

    task automatic drive(input bit st, input bit ps, input bit cl, input bit co);
        intf.start     = st;
        intf.pause     = ps;
        intf.clear     = cl;
        intf.collision = co;
    endtask

    task automatic cycle(input bit st, input bit ps, input bit cl, input bit co);
        @(negedge clk);
        rst = 1'b0;
        drive(st, ps, cl, co);
        model_step(st, ps, cl, co);
        push_exp();
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        push_exp();
    endtask

    // Reset asserted between edges must clear the outputs before the next edge.
    task automatic async_reset_check();
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (intf.ones !== 4'd0 || intf.tens !== 4'd0 || intf.running !== 1'b0 ||
            intf.done !== 1'b0 || intf.sec_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got ones=%0d tens=%0d run=%0b done=%0b pulse=%0b want all zero",
                     intf.ones, intf.tens, intf.running, intf.done, intf.sec_pulse);
        end
        model_reset();
        push_exp();
    endtask

    task automatic run_until(input int secs, input int phase, input int limit, input string name);
        int n = 0;
        while (!(m_mode == M_RUN && m_secs == secs && m_phase == phase) && n < limit) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL %s bound expired after %0d cycles at secs=%0d want %0d", name, n, m_secs, secs);
        end
    endtask

    // Monitor: compares every registered output sample against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (intf.ones !== 4'(e.ones) || intf.tens !== 4'(e.tens) ||
                    intf.running !== e.running || intf.done !== e.done ||
                    intf.sec_pulse !== e.pulse) begin
                    errors++;
                    $display("FAIL outputs t=%0t got ones=%0d tens=%0d run=%0b done=%0b pulse=%0b want ones=%0d tens=%0d run=%0b done=%0b pulse=%0b",
                             $time, intf.ones, intf.tens, intf.running, intf.done, intf.sec_pulse,
                             e.ones, e.tens, e.running, e.done, e.pulse);
                end
                checks++;
                if (intf.ones > 4'd9 || intf.tens > 4'(MT)) begin
                    errors++;
                    $display("FAIL bcd_legal t=%0t got ones=%0d tens=%0d want <=9 and <=%0d",
                             $time, intf.ones, intf.tens, MT);
                end
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        reset_cycle();
        reset_cycle();

        // Free run 00 -> 10, then continue to 37 and reset mid-count.
        repeat (41) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_until(37, 1, 200, "reach_37");
        async_reset_check();
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Pause with held prescaler phase at 05, then resume.
        run_until(5, 1, 100, "reach_05");
        repeat (9) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation at 99, start ignored in OVER, clear back to IDLE.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 500 && m_mode != M_OVER; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Collision coinciding with a tick at 12, then clear+start together.
        run_until(12, T - 1, 100, "reach_12");
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Pause coinciding with a tick at 20.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        run_until(20, T - 1, 200, "reach_20");
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Random control traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                async_reset_check();
            end else begin
                cycle(($urandom_range(3, 0) != 0), ($urandom_range(7, 0) == 0),
                      ($urandom_range(63, 0) == 0), ($urandom_range(127, 0) == 0));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
